uv_spi_slave: RTL and testbench
===============================

UV_SPI_SLAVE -- requirements
Module: uv_spi_slave

Interface
REQ-001 SHALL have parameter RXQ_AW, default 3, RX queue address width (depth 2**RXQ_AW bytes).
REQ-002 SHALL have parameter TXQ_AW, default 3, TX queue address width (depth 2**TXQ_AW bytes).
REQ-003 SHALL have parameter TX_IDLE, default 8'hFF, byte shifted out on TX underflow.
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk input 1 system clock; rst_n input 1 async active-low reset.
REQ-005 SHALL have port spi_cs input 1, chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port spi_sck input 1, serial clock from master, asynchronous to clk.
REQ-007 SHALL have port spi_mosi input 1, serial data from master.
REQ-008 SHALL have port spi_miso output 1, serial data to master.
REQ-009 SHALL have port spi_miso_oe output 1, MISO output enable.
REQ-010 SHALL have ports rx_vld output 1, rx_rdy input 1, rx_data output 8: received-byte stream.
REQ-011 SHALL have ports tx_vld input 1, tx_rdy output 1, tx_data input 8: transmit-byte stream.
REQ-012 SHALL have ports sts_clr input 1 (clears sticky flags), rx_ovf output 1, tx_udf output 1, spi_irq output 1.

Function
REQ-013 SHALL support SPI mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit frames.
REQ-014 SHALL pass spi_cs, spi_sck and spi_mosi through 2-flop synchronizers; edges detected on synchronized sck; clk SHALL be >= 4x sck.
REQ-015 SHALL run FSM IDLE -> ACTIVE on synchronized cs falling edge, ACTIVE -> IDLE on cs rising edge.
REQ-016 SHALL, on entering ACTIVE, pop TX queue head into the shift register, or load TX_IDLE and set tx_udf if empty; spi_miso = bit7 the next cycle.
REQ-017 SHALL sample mosi on each sck rising edge into the RX shift register; 3-bit counter increments, wraps 7 -> 0.
REQ-018 SHALL, on the 8th rising edge, push the assembled byte to the RX queue; if full, drop the byte and set rx_ovf.
REQ-019 SHALL shift the next TX bit onto spi_miso on each sck falling edge; after the 8th falling edge, load the next byte per REQ-016.
REQ-020 SHALL, on cs rising mid-byte, discard the partial RX byte, reset the bit counter, return to IDLE; an already-loaded TX byte is lost.
REQ-021 SHALL drive spi_miso_oe = 1 only in ACTIVE; spi_miso = 0 in IDLE.
REQ-022 SHALL implement the rx and tx streams as valid/ready: transfer when vld & rdy; rx_vld = RX queue not empty; tx_rdy = TX queue not full.
REQ-023 SHALL allow simultaneous push and pop on one queue in one cycle; count unchanged.
REQ-024 SHALL keep rx_ovf and tx_udf sticky until sts_clr; a set event coinciding with sts_clr wins (flag stays 1).

Reset
REQ-025 SHALL on rst_n low: FSM IDLE, queues empty, counter 0, spi_miso 0, spi_miso_oe 0, rx_vld 0, tx_rdy 1, rx_ovf 0, tx_udf 0, spi_irq 0.
REQ-026 SHALL release reset cleanly mid-transfer: the in-flight frame is abandoned, and the block waits for the next cs falling edge.

Configuration
REQ-027 SHALL with UV_SPI_SLAVE_IRQ_EN defined drive spi_irq = rx_vld | rx_ovf | tx_udf, registered, 1-cycle latency.
REQ-028 SHALL without UV_SPI_SLAVE_IRQ_EN tie spi_irq to 0 and include no irq logic; all else identical.

Structure
REQ-029 SHALL place SPI mode, frame width (8) and TX_IDLE default constants in shared package uv_spi_pkg.
REQ-030 SHALL use one sub-module uv_spi_slv_shifter (synchronizers, edge detect, shift registers, bit counter); queues reuse the existing codebase FIFO.

Verification
REQ-031 SHALL cover basic exchange: TX queue preloaded 8'hA5; master sends 8'h3C -> master reads 8'hA5; rx_data 8'h3C appears.
REQ-032 SHALL cover underflow: TX queue empty; master sends 8'h12 -> MISO returns 8'hFF; tx_udf=1; rx_data 8'h12.
REQ-033 SHALL cover overflow: rx_rdy=0, master sends 9 bytes with RXQ_AW=3 -> first 8 bytes held; 9th dropped; rx_ovf=1; sts_clr -> 0.
REQ-034 SHALL cover abort: cs deasserted after 5 bits -> no RX push, counter 0; next 8-bit frame 8'h55 received intact.
REQ-035 SHALL cover back-to-back: TX preloaded 8'h01,8'h02,8'h03; 3 continuous frames -> MISO 01,02,03 with no gap bit.
REQ-036 SHALL cover irq: with UV_SPI_SLAVE_IRQ_EN, first RX byte -> spi_irq=1 one cycle after rx_vld; without the macro, spi_irq stays 0.

Source files
------------

// File: rtl/uv_spi_pkg.sv
// rtl/uv_spi_pkg.sv - shared SPI mode, frame width and idle-byte constants
package uv_spi_pkg;

    // {CPOL, CPHA}; only mode 0 is implemented
    localparam logic [1:0] SPI_MODE = 2'b00;
    localparam int unsigned FRAME_W = 8;
    localparam logic [FRAME_W-1:0] TX_IDLE_DEF = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/uv_spi_fifo.sv
// rtl/uv_spi_fifo.sv - show-ahead FIFO, push ignored when full, pop ignored when empty
module uv_spi_fifo #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uv_spi_slv_shifter.sv
// rtl/uv_spi_slv_shifter.sv - SPI pin synchronizers, edge detect, shift registers, bit counter
module uv_spi_slv_shifter
    import uv_spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_cs,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    input  logic               active,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    output logic               cs_fall,
    output logic               cs_rise,
    output logic               rx_push,
    output logic [FRAME_W-1:0] rx_byte,
    output logic               tx_need,
    output logic               miso_bit
);

    localparam logic SCK_IDLE = SPI_MODE[1];

    logic [1:0]         cs_sync;
    logic [1:0]         sck_sync;
    logic [1:0]         mosi_sync;
    logic               cs_q;
    logic               sck_q;
    logic               sck_rise;
    logic               sck_fall;
    logic [2:0]         bit_cnt;
    logic [FRAME_W-1:0] rx_sr;
    logic [FRAME_W-1:0] tx_sr;

    // cs chain resets as "selected" so a cs already low at reset release is not seen as a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= 2'b00;
            cs_q      <= 1'b0;
            sck_sync  <= {2{SCK_IDLE}};
            sck_q     <= SCK_IDLE;
            mosi_sync <= 2'b00;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs};
            cs_q      <= cs_sync[1];
            sck_sync  <= {sck_sync[0], spi_sck};
            sck_q     <= sck_sync[1];
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign cs_fall  = cs_q & ~cs_sync[1];
    assign cs_rise  = ~cs_q & cs_sync[1];
    assign sck_rise = active & sck_sync[1] & ~sck_q;
    assign sck_fall = active & ~sck_sync[1] & sck_q;

    assign rx_byte  = {rx_sr[FRAME_W-2:0], mosi_sync[1]};
    assign rx_push  = sck_rise & (bit_cnt == 3'd7);
    // counter already wrapped to 0 on a falling edge means the frame's last bit has gone out
    assign tx_need  = sck_fall & (bit_cnt == 3'd0);
    assign miso_bit = tx_sr[FRAME_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
            rx_sr   <= '0;
            tx_sr   <= '0;
        end else begin
            if (!active) begin
                bit_cnt <= 3'd0;
                rx_sr   <= '0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= rx_byte;
            end
            if (load) begin
                tx_sr <= load_data;
            end else if (sck_fall) begin
                tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/uv_spi_slave.sv
// rtl/uv_spi_slave.sv - SPI mode-0 slave with RX/TX byte queues; UV_SPI_SLAVE_IRQ_EN enables spi_irq
module uv_spi_slave
    import uv_spi_pkg::*;
#(
    parameter int         RXQ_AW  = 3,
    parameter int         TXQ_AW  = 3,
    parameter logic [7:0] TX_IDLE = TX_IDLE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cs,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       rx_vld,
    input  logic       rx_rdy,
    output logic [7:0] rx_data,
    input  logic       tx_vld,
    output logic       tx_rdy,
    input  logic [7:0] tx_data,
    input  logic       sts_clr,
    output logic       rx_ovf,
    output logic       tx_udf,
    output logic       spi_irq
);

    spi_state_e state;
    spi_state_e state_nxt;
    logic       active;
    logic       load;
    logic       cs_fall;
    logic       cs_rise;
    logic       rx_push;
    logic       tx_need;
    logic       miso_bit;
    logic [7:0] rx_byte;
    logic [7:0] tx_head;
    logic [7:0] load_data;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;

    assign active = (state == ST_ACTIVE);

    uv_spi_slv_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_cs    (spi_cs),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .active    (active),
        .load      (load),
        .load_data (load_data),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .rx_push   (rx_push),
        .rx_byte   (rx_byte),
        .tx_need   (tx_need),
        .miso_bit  (miso_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_nxt = ST_ACTIVE;
                    load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise)      state_nxt = ST_IDLE;
                else if (tx_need) load      = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign load_data = tx_empty ? TX_IDLE : tx_head;

    uv_spi_fifo #(.AW(RXQ_AW), .DW(8)) u_rxq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .wdata (rx_byte),
        .pop   (rx_rdy),
        .rdata (rx_data),
        .empty (rx_empty),
        .full  (rx_full)
    );

    uv_spi_fifo #(.AW(TXQ_AW), .DW(8)) u_txq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_vld),
        .wdata (tx_data),
        .pop   (load),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    assign rx_vld      = ~rx_empty;
    assign tx_rdy      = ~tx_full;
    assign spi_miso_oe = active;
    assign spi_miso    = active & miso_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovf <= 1'b0;
            tx_udf <= 1'b0;
        end else begin
            rx_ovf <= (rx_push & rx_full) | (rx_ovf & ~sts_clr);
            tx_udf <= (load & tx_empty) | (tx_udf & ~sts_clr);
        end
    end

`ifdef UV_SPI_SLAVE_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= rx_vld | rx_ovf | tx_udf;
    end
    assign spi_irq = irq_q;
`else
    assign spi_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uv_spi_slave.sv
// tb/tb_uv_spi_slave.sv - randomized self-checking bench for uv_spi_slave with a queue-based reference model
module tb_uv_spi_slave;

    localparam int         HALF      = 80;
    localparam int         RXQ_DEPTH = 8;
    localparam int         TXQ_DEPTH = 8;
    localparam logic [7:0] IDLE_BYTE = 8'hFF;
`ifdef UV_SPI_SLAVE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_cs = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       rx_vld;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       tx_vld = 1'b0;
    logic       tx_rdy;
    logic [7:0] tx_data = 8'h00;
    logic       sts_clr = 1'b0;
    logic       rx_ovf;
    logic       tx_udf;
    logic       spi_irq;

    always #5 clk = ~clk;

    uv_spi_slave #(.RXQ_AW(3), .TXQ_AW(3), .TX_IDLE(8'hFF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_cs      (spi_cs),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rx_vld      (rx_vld),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .tx_vld      (tx_vld),
        .tx_rdy      (tx_rdy),
        .tx_data     (tx_data),
        .sts_clr     (sts_clr),
        .rx_ovf      (rx_ovf),
        .tx_udf      (tx_udf),
        .spi_irq     (spi_irq)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] m_txq[$];
    logic [7:0] m_rxq[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] mosi_q[$];
    logic [7:0] miso_got[$];
    logic [7:0] exp_miso[$];

    function automatic logic [7:0] model_pop_tx();
        if (m_txq.size() == 0) begin
            m_udf = 1'b1;
            return IDLE_BYTE;
        end
        return m_txq.pop_front();
    endfunction

    // one cs-low session: a byte is taken at select and again after every complete frame
    task automatic model_session(input int nbits);
        logic [7:0] cur;
        exp_miso.delete();
        cur = model_pop_tx();
        for (int f = 0; f < nbits / 8; f++) begin
            exp_miso.push_back(cur);
            if (m_rxq.size() < RXQ_DEPTH) m_rxq.push_back(mosi_q[f]);
            else                          m_ovf = 1'b1;
            cur = model_pop_tx();
        end
    endtask

    task automatic spi_session(input int nbits);
        logic [7:0] sh;
        sh = 8'h00;
        miso_got.delete();
        @(negedge clk);
        spi_cs = 1'b0;
        #(2 * HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mosi_q[i / 8][7 - (i % 8)];
            #(HALF);
            spi_sck = 1'b1;
            sh = {sh[6:0], spi_miso};
            if (i == 0) begin
                n_checks++;
                if (spi_miso_oe !== 1'b1) begin
                    n_fail++;
                    $display("FAIL miso_oe_active: got %b expected 1", spi_miso_oe);
                end
            end
            if (i % 8 == 7) miso_got.push_back(sh);
            #(HALF);
            spi_sck = 1'b0;
        end
        #(HALF);
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        #(2 * HALF);
    endtask

    task automatic check_miso(input string name);
        n_checks++;
        if (miso_got.size() != exp_miso.size()) begin
            n_fail++;
            $display("FAIL %s miso_count: got %0d expected %0d", name, miso_got.size(), exp_miso.size());
        end
        for (int i = 0; i < miso_got.size() && i < exp_miso.size(); i++) begin
            n_checks++;
            if (miso_got[i] !== exp_miso[i]) begin
                n_fail++;
                $display("FAIL %s miso[%0d]: got %h expected %h", name, i, miso_got[i], exp_miso[i]);
            end
        end
    endtask

    task automatic drain_rx(input string name);
        logic [7:0] e;
        while (m_rxq.size() > 0) begin
            e = m_rxq.pop_front();
            @(negedge clk);
            n_checks++;
            if (rx_vld !== 1'b1 || rx_data !== e) begin
                n_fail++;
                $display("FAIL %s rx: got vld=%b data=%h expected vld=1 data=%h", name, rx_vld, rx_data, e);
            end
            rx_rdy = 1'b1;
            @(negedge clk);
            rx_rdy = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (rx_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rx_empty: got rx_vld=%b expected 0", name, rx_vld);
        end
    endtask

    task automatic check_flags(input string name);
        @(negedge clk);
        n_checks++;
        if (rx_ovf !== m_ovf) begin
            n_fail++;
            $display("FAIL %s rx_ovf: got %b expected %b", name, rx_ovf, m_ovf);
        end
        n_checks++;
        if (tx_udf !== m_udf) begin
            n_fail++;
            $display("FAIL %s tx_udf: got %b expected %b", name, tx_udf, m_udf);
        end
    endtask

    task automatic clear_flags(input string name);
        @(negedge clk);
        sts_clr = 1'b1;
        @(negedge clk);
        sts_clr = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_flags(name);
    endtask

    task automatic push_tx(input logic [7:0] d);
        logic acc;
        @(negedge clk);
        tx_vld  = 1'b1;
        tx_data = d;
        acc     = (m_txq.size() < TXQ_DEPTH);
        n_checks++;
        if (tx_rdy !== acc) begin
            n_fail++;
            $display("FAIL tx_rdy: got %b expected %b", tx_rdy, acc);
        end
        @(posedge clk);
        if (acc) m_txq.push_back(d);
        @(negedge clk);
        tx_vld = 1'b0;
    endtask

    task automatic check_idle_pins(input string name);
        @(negedge clk);
        n_checks++;
        if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_pins: got miso=%b oe=%b expected 0 0", name, spi_miso, spi_miso_oe);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({spi_miso, spi_miso_oe, rx_vld, tx_rdy, rx_ovf, tx_udf, spi_irq} !== 7'b0001000) begin
            n_fail++;
            $display("FAIL reset_outputs: got miso,oe,rxv,txr,ovf,udf,irq=%b expected 0001000",
                     {spi_miso, spi_miso_oe, rx_vld, tx_rdy, rx_ovf, tx_udf, spi_irq});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_pins("reset_release");
    endtask

    task automatic test_basic();
        push_tx(8'hA5);
        mosi_q = '{8'h3C};
        model_session(8);
        spi_session(8);
        check_miso("basic");
        check_idle_pins("basic");
        drain_rx("basic");
        check_flags("basic");
        clear_flags("basic_clr");
    endtask

    task automatic test_underflow();
        mosi_q = '{8'h12};
        model_session(8);
        spi_session(8);
        check_miso("underflow");
        drain_rx("underflow");
        check_flags("underflow");
        clear_flags("underflow_clr");
    endtask

    task automatic test_overflow();
        mosi_q.delete();
        for (int i = 0; i < 9; i++) mosi_q.push_back(8'($urandom_range(0, 255)));
        model_session(72);
        spi_session(72);
        check_miso("overflow");
        check_flags("overflow");
        clear_flags("overflow_clr");
        drain_rx("overflow");
    endtask

    task automatic test_abort();
        push_tx(8'($urandom_range(0, 255)));
        mosi_q = '{8'($urandom_range(0, 255))};
        model_session(5);
        spi_session(5);
        drain_rx("abort_partial");
        mosi_q = '{8'h55};
        model_session(8);
        spi_session(8);
        check_miso("abort_next");
        drain_rx("abort_next");
        check_flags("abort");
        clear_flags("abort_clr");
    endtask

    task automatic test_back_to_back();
        push_tx(8'h01);
        push_tx(8'h02);
        push_tx(8'h03);
        mosi_q.delete();
        for (int i = 0; i < 3; i++) mosi_q.push_back(8'($urandom_range(0, 255)));
        model_session(24);
        spi_session(24);
        check_miso("back_to_back");
        drain_rx("back_to_back");
        check_flags("back_to_back");
        clear_flags("back_to_back_clr");
    endtask

    task automatic test_irq();
        int budget;
        push_tx(8'($urandom_range(0, 255)));
        push_tx(8'($urandom_range(0, 255)));
        mosi_q = '{8'($urandom_range(0, 255))};
        model_session(8);
        budget = 400;
        fork
            spi_session(8);
            begin
                while (rx_vld !== 1'b1 && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
                n_checks++;
                if (budget == 0) begin
                    n_fail++;
                    $display("FAIL irq_wait: got no rx_vld within 400 cycles expected rx_vld=1");
                end else begin
                    n_checks++;
                    if (spi_irq !== 1'b0) begin
                        n_fail++;
                        $display("FAIL irq_lag: got %b expected 0", spi_irq);
                    end
                    @(negedge clk);
                    n_checks++;
                    if (spi_irq !== IRQ_ON) begin
                        n_fail++;
                        $display("FAIL irq_assert: got %b expected %b", spi_irq, IRQ_ON);
                    end
                end
            end
        join
        check_miso("irq");
        drain_rx("irq");
        check_flags("irq");
    endtask

    task automatic test_reset_mid();
        push_tx(8'($urandom_range(0, 255)));
        @(negedge clk);
        spi_cs = 1'b0;
        #(2 * HALF);
        for (int i = 0; i < 8; i++) begin
            spi_mosi = 1'($urandom_range(0, 1));
            #(HALF);
            spi_sck = 1'b1;
            #(HALF);
            spi_sck = 1'b0;
            if (i == 2) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                m_txq.delete();
                m_rxq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end
        n_checks++;
        if (spi_miso_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_oe: got %b expected 0", spi_miso_oe);
        end
        #(HALF);
        spi_cs = 1'b1;
        #(2 * HALF);
        drain_rx("reset_mid");
        check_flags("reset_mid");
        mosi_q = '{8'($urandom_range(0, 255))};
        model_session(8);
        spi_session(8);
        check_miso("reset_mid_next");
        drain_rx("reset_mid_next");
        check_flags("reset_mid_next");
        clear_flags("reset_mid_clr");
    endtask

    task automatic test_random();
        int k;
        int n;
        for (int it = 0; it < 5; it++) begin
            k = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) push_tx(8'($urandom_range(0, 255)));
            mosi_q.delete();
            for (int j = 0; j < n; j++) mosi_q.push_back(8'($urandom_range(0, 255)));
            model_session(8 * n);
            spi_session(8 * n);
            check_miso("random");
            drain_rx("random");
            check_flags("random");
            clear_flags("random_clr");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
